// File: rtl/s1_cache_pkg.sv
// s1_cache_pkg: shared defaults, FSM state type and index/tag width helpers for the S1 read cache
package s1_cache_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 16;
    localparam int LINES_DEF  = 16;

    typedef enum logic [1:0] {IDLE, MEM, RESP} state_t;

    function automatic int idx_w(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_w(input int addr_w, input int lines);
        return addr_w - $clog2(lines);
    endfunction

endpackage

// File: rtl/s1_cache_lines.sv
// s1_cache_lines: direct-mapped valid/tag/data storage with combinational lookup, one write port and flush-all
module s1_cache_lines
    import s1_cache_pkg::*;
#(
    parameter int LINES  = LINES_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              hit,
    output logic [DATA_W-1:0] rd_data,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    localparam int IW = idx_w(LINES);
    localparam int TW = tag_w(ADDR_W, LINES);

    logic [LINES-1:0]  valid;
    logic [TW-1:0]     tags [LINES];
    logic [DATA_W-1:0] data [LINES];
    logic [IW-1:0]     ri;
    logic [IW-1:0]     wi;

    assign ri      = rd_addr[IW-1:0];
    assign wi      = wr_addr[IW-1:0];
    assign hit     = valid[ri] && (tags[ri] == rd_addr[ADDR_W-1:IW]);
    assign rd_data = data[ri];

    // valid bits: cleared by reset or flush, set when a line is filled or updated
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
        end else begin
            if (flush)
                valid <= '0;
            if (we)
                valid[wi] <= 1'b1;
        end
    end

    // tag and data payload need no reset since valid gates every use
    always_ff @(posedge clk) begin
        if (we) begin
            tags[wi] <= wr_addr[ADDR_W-1:IW];
            data[wi] <= wr_data;
        end
    end

endmodule

// File: rtl/s1_read_cache.sv
// s1_read_cache: direct-mapped write-through single-word-line cache between S1 and memory; S1_CACHE_STATS_EN adds hit/miss counters
module s1_read_cache
    import s1_cache_pkg::*;
#(
    parameter int LINES  = LINES_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] inputAddress,
    input  logic [DATA_W-1:0] inputWdata,
    input  logic              inputWnR,
    input  logic              inputSelect,
    output logic [DATA_W-1:0] outputRdata,
    output logic              outputValid,
    input  logic              inputFlush,
    output logic [ADDR_W-1:0] outputAddress,
    output logic [DATA_W-1:0] outputWdata,
    output logic              outputWnR,
    output logic              outputSelect,
    input  logic [DATA_W-1:0] inputRdata,
    input  logic              inputValid
`ifdef S1_CACHE_STATS_EN
    ,
    output logic [15:0]       outputHitCount,
    output logic [15:0]       outputMissCount
`endif
);

    state_t            state;
    logic              flush_pend;
    logic              do_flush;
    logic              hit;
    logic              we;
    logic              hit_done;
    logic              miss_done;
    logic [ADDR_W-1:0] lk_addr;
    logic [DATA_W-1:0] lk_data;
    logic [DATA_W-1:0] wr_data;

    // a flush only takes effect at an IDLE edge, whether fresh or left pending from a busy state
    assign do_flush  = (state == IDLE) && (inputFlush || flush_pend);
    assign lk_addr   = (state == IDLE) ? inputAddress : outputAddress;
    assign hit_done  = (state == IDLE) && inputSelect && !inputWnR && hit && !do_flush;
    assign miss_done = (state == MEM) && inputValid && !outputWnR;
    assign we        = (state == MEM) && inputValid && (!outputWnR || hit);
    assign wr_data   = outputWnR ? outputWdata : inputRdata;

    s1_cache_lines #(
        .LINES  (LINES),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_lines (
        .clk     (clk),
        .rst     (rst),
        .flush   (do_flush),
        .rd_addr (lk_addr),
        .hit     (hit),
        .rd_data (lk_data),
        .we      (we),
        .wr_addr (outputAddress),
        .wr_data (wr_data)
    );

    // request FSM; the captured request lives directly in the memory-side output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            flush_pend    <= 1'b0;
            outputValid   <= 1'b0;
            outputSelect  <= 1'b0;
            outputWnR     <= 1'b0;
            outputAddress <= '0;
            outputWdata   <= '0;
            outputRdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    flush_pend <= 1'b0;
                    if (inputSelect) begin
                        outputAddress <= inputAddress;
                        outputWdata   <= inputWdata;
                        outputWnR     <= inputWnR;
                        if (hit_done) begin
                            outputRdata <= lk_data;
                            outputValid <= 1'b1;
                            state       <= RESP;
                        end else begin
                            outputSelect <= 1'b1;
                            state        <= MEM;
                        end
                    end
                end
                MEM: begin
                    flush_pend <= flush_pend | inputFlush;
                    if (inputValid) begin
                        outputSelect <= 1'b0;
                        outputValid  <= 1'b1;
                        state        <= RESP;
                        if (!outputWnR)
                            outputRdata <= inputRdata;
                    end
                end
                RESP: begin
                    flush_pend  <= flush_pend | inputFlush;
                    outputValid <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef S1_CACHE_STATS_EN
    // saturating counters of completed reads, bumped on the transition into RESP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outputHitCount  <= '0;
            outputMissCount <= '0;
        end else begin
            if (hit_done && outputHitCount != 16'hFFFF)
                outputHitCount <= outputHitCount + 16'd1;
            if (miss_done && outputMissCount != 16'hFFFF)
                outputMissCount <= outputMissCount + 16'd1;
        end
    end
`endif

endmodule

// File: doc/s1_read_cache.md
Name: s1_read_cache

Overview:
- Small direct-mapped, write-through, single-word-line cache between the S1 core bus and MemoryModel.
- Sits directly downstream of S1 and upstream of MemoryModel, speaking the same select/wnr/valid handshake on both sides.
- Read hits return in one cycle; misses and all writes are forwarded to memory.

Parameters:
- LINES, 16, number of cache lines; power of two, 2..256.
- ADDR_W, 12, word address width.
- DATA_W, 16, data width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- inputAddress  input  ADDR_W  core request address.
- inputWdata  input  DATA_W  core write data.
- inputWnR  input  1  1=write, 0=read.
- inputSelect  input  1  core request strobe.
- outputRdata  output  DATA_W  read data to core.
- outputValid  output  1  one-cycle completion pulse to core.
- inputFlush  input  1  invalidate all lines.
- outputAddress  output  ADDR_W  address to memory.
- outputWdata  output  DATA_W  write data to memory.
- outputWnR  output  1  write/read to memory.
- outputSelect  output  1  memory request strobe.
- inputRdata  input  DATA_W  memory read data.
- inputValid  input  1  memory completion pulse.

Behaviour:
- Bus rule, both sides:
  - Requester holds select, address, wnr and wdata stable until valid is high for one cycle.
  - In the cycle after valid, select is either low or a new request.
- Address split: index = addr[log2(LINES)-1:0], tag = remaining upper bits. Each line holds a valid bit, a tag and a data word.
- Reset (async) sets:
  - all valid bits = 0 and state = IDLE;
  - outputValid, outputSelect, outputWnR = 0;
  - outputAddress, outputWdata, outputRdata = 0.
- Reset mid-transaction abandons the memory access. outputSelect drops immediately. A late inputValid is ignored while in IDLE.
- FSM states: IDLE, MEM, RESP.
- IDLE:
  - On a clock edge with inputSelect=1, capture address, wnr and wdata.
  - Read hit (valid and tag match): latch line data into outputRdata, go to RESP.
  - Read miss, or any write: go to MEM.
- MEM:
  - outputSelect=1; outputAddress, outputWnR and outputWdata come from the captured request.
  - Remain in MEM until inputValid=1. On that edge:
    - read: write inputRdata into the line, set valid and tag, copy inputRdata to outputRdata;
    - write hit: update the line data with the captured wdata;
    - write miss: no allocate.
  - Then go to RESP.
- RESP: outputValid=1 for exactly one cycle, then go to IDLE. outputRdata holds its value until the next response. outputRdata is don't-care for writes, but the block drives it unchanged.
- Latency, counted from the edge at which select is sampled:
  - read hit: outputValid high in the next cycle (1 cycle);
  - miss/write: memory latency + 1.
- outputSelect is low in IDLE and RESP, so there is never a back-to-back memory select without a gap cycle.
- Flush:
  - inputFlush=1 at an IDLE edge clears all valid bits in that cycle.
  - If inputFlush and inputSelect are both high at the same IDLE edge, the flush applies first and the request is treated as a miss.
  - inputFlush while in MEM or RESP sets a pending flag. The flush executes on the first IDLE edge; a request sampled at that same edge is treated as a miss.
- The wrap-around address 12'hFFF is treated as an ordinary address; there is no address arithmetic.

Optional Feature:
- Macro: S1_CACHE_STATS_EN.
- With the macro defined, two extra outputs exist: outputHitCount[15:0] and outputMissCount[15:0].
  - They count completed reads only, incrementing on the transition into RESP.
  - Both saturate at 16'hFFFF, reset to 0, and are not cleared by flush.
- Without the macro, these ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package s1_cache_pkg: ADDR_W/DATA_W defaults, state enum (IDLE, MEM, RESP), index/tag width helper constants.
- Sub-module s1_cache_lines holds the valid/tag/data arrays:
  - combinational lookup returning hit and data;
  - single write port;
  - flush-all input.

Test Plan:
- Read of 12'h010 after reset (memory holds 16'hBEEF) -> miss, outputSelect high until memory valid, outputValid one cycle later with 16'hBEEF. A repeat read of 12'h010 -> hit, outputValid in the next cycle, outputSelect stays 0.
- Write 16'h1234 to 12'h010, then read 12'h010 -> the write passes through to memory (outputWnR=1). The subsequent read hits and returns 16'h1234.
- Read 12'h010 then 12'h020 (same index, LINES=16), then 12'h010 again -> three misses, each returning correct memory data.
- Flush asserted while in MEM, followed by a read of a previously cached address -> the pending flush applies and the read misses.
- Assert rst while in MEM -> outputSelect and outputValid go to 0 immediately. A read of the earlier-cached address then misses.
- With S1_CACHE_STATS_EN defined, the first scenario -> outputHitCount=1, outputMissCount=1.
